game_session_ctrl: RTL
======================

# game_session_ctrl

Session sequencer for the Pong `Game` datapath. It runs a fixed number of rounds per session and drives the Game start/end valid-ready handshakes. It gates decoded paddle commands onto `paddle_control` only while a round is live, and inserts a rest gap between rounds. It keeps session-level win/lose/round totals for the host and stimulation logic.

## Interface
Parameters:
- `NUM_ROUNDS`, 8: rounds per session; legal range 1..255.
- `REST_CYCLES`, 16: idle cycles between rounds; must be ≥1.
- `ROUND_TIMEOUT`, 4096: maximum cycles in RUN before the session aborts.
- `CMD_HOLD`, 4: cycles a decoded paddle command stays asserted.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `session_start` in 1: one-cycle pulse; ignored unless IDLE.
- `session_abort` in 1: one-cycle pulse; ends the session early.
- `game_start_valid` out 1: to Game.
- `game_start_ready` in 1: from Game.
- `game_end_valid` out 1: to Game.
- `game_end_ready` in 1: from Game.
- `result_en` in 1: level from Game, high while Game is in END.
- `game_result` in 1: 1 = win.
- `cmd_valid` in 1: decoder command strobe.
- `cmd` in 2: [1] = up, [0] = down.
- `paddle_control` out 2: to Game.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at session end.
- `timeout_flag` out 1: sticky; cleared by the next `session_start`.
- `round_count` out 8: rounds completed.
- `win_total` out 8: rounds won.
- `lose_total` out 8: rounds lost.

## Operation
- States: IDLE, START, RUN, REST, FINISH, DONE.
- IDLE: on `session_start`, clear `round_count`, `win_total`, `lose_total`, `timeout_flag` and the abort latch; go to START.
- START: hold `game_start_valid`=1 until `game_start_valid && game_start_ready`. On the handshake, clear the round timer and go to RUN.
- RUN: paddle gating active. The round timer increments each cycle.
  - A result is detected on a `result_en` rising edge, using a registered copy of `result_en`. Each round is counted exactly once, although `result_en` stays high.
  - On a result:
    - `round_count`++.
    - `win_total`++ if `game_result`=1, otherwise `lose_total`++.
    - Go to FINISH if the new count equals `NUM_ROUNDS` or the abort latch is set; otherwise go to REST.
  - Timeout: if the timer reaches `ROUND_TIMEOUT-1` with no result, set `timeout_flag` and go to DONE. No end handshake is issued because Game cannot accept one while running; the top level must reset Game.
- REST: `paddle_control`=0. Wait `REST_CYCLES` cycles, then go to START.
- FINISH: hold `game_end_valid`=1 until the handshake completes, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. Totals hold until the next start.
- Abort handling:
  - `session_abort` in RUN sets the abort latch; it takes effect at the next result.
  - In REST it goes to FINISH immediately.
  - In START it drops `game_start_valid` and goes to FINISH if `game_end_ready`=1, otherwise to DONE.
  - In IDLE, FINISH or DONE it is ignored.
- Paddle hold:
  - In RUN, `cmd_valid` with `cmd` ∈ {2'b10, 2'b01} loads the command and sets a hold counter to `CMD_HOLD`.
  - `paddle_control` equals the loaded command while the counter is non-zero; the counter decrements each cycle.
  - A new valid command restarts the hold, last one wins.
  - `cmd` 2'b11 or 2'b00 with `cmd_valid` forces `paddle_control`=0 and clears the hold.
  - Leaving RUN clears the hold immediately.
- Arithmetic: `win_total` and `lose_total` saturate at 255. The round timer width is clog2(`ROUND_TIMEOUT`). The rest and hold counters are sized from their parameters.

## Timing
- All outputs are registered. Reset values:
  - State IDLE.
  - `game_start_valid`, `game_end_valid`, `paddle_control`, `busy`, `done`, `timeout_flag` all 0.
  - All counters 0.
- `session_start` at edge N: `busy` and `game_start_valid` are 1 from cycle N+1.
- Game's ready is combinational from its state, so the START handshake normally completes in the first START cycle.
- `result_en` rising at cycle R: the totals and the state change are visible at R+1.
- `paddle_control` follows `cmd_valid` one cycle later.
- A session with no timeout runs `NUM_ROUNDS` round lengths, plus `NUM_ROUNDS`-1 rests of `REST_CYCLES`, plus one START cycle per round, plus the FINISH and DONE cycles.
- Asynchronous reset mid-session returns to reset values immediately. No handshake is completed.

## Structure
- Package `game_ctrl_pkg`:
  - Session state encoding.
  - Paddle command constants: `PADDLE_UP`=2'b10, `PADDLE_DOWN`=2'b01, `PADDLE_IDLE`=2'b00.
  - Shared counter width (8).
- One sub-module, `paddle_cmd_hold`: inputs are the command, strobe, enable and `CMD_HOLD`; output is `paddle_control`.

## Test plan
- `NUM_ROUNDS`=3, Game returns win, lose, win → `win_total`=2, `lose_total`=1, `round_count`=3; exactly one end handshake; `done` pulses once.
- `result_en` held high for 5 cycles → `round_count` increments by exactly 1.
- `session_abort` mid-RUN in round 1 of 8 → FINISH after round-1 result; `round_count`=1; `done` pulses.
- No `result_en` for `ROUND_TIMEOUT` cycles → `timeout_flag`=1; `done` pulses; `game_end_valid` never asserted.
- `cmd`=2'b10 strobed once with `CMD_HOLD`=4 → `paddle_control`=2'b10 for exactly 4 cycles. `cmd`=2'b11 → 2'b00. `cmd` during REST → 2'b00.
- `reset` asserted during START with valid high → `game_start_valid`=0 at once; state IDLE; counters 0.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared state encoding, paddle command codes and counter helpers for the
// Pong session controller.
package game_ctrl_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REST   = 3'd3,
        ST_FINISH = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [1:0] PADDLE_UP   = 2'b10;
    localparam logic [1:0] PADDLE_DOWN = 2'b01;
    localparam logic [1:0] PADDLE_IDLE = 2'b00;

    // Totals stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/paddle_cmd_hold.sv
// Stretches a single decoded paddle strobe over CMD_HOLD cycles; the output
// drops to idle as soon as enable is withdrawn.
module paddle_cmd_hold
    import game_ctrl_pkg::*;
#(
    parameter int unsigned CMD_HOLD = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] cmd_i,
    input  logic       cmd_valid_i,
    input  logic       en_i,
    output logic [1:0] paddle_control_o
);

    localparam int HOLD_W = $clog2(CMD_HOLD + 1);
    // The load cycle itself is the first held cycle, so the counter starts one short.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CMD_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [1:0]        paddle_q;
    logic              is_move;

    assign is_move = (cmd_i == PADDLE_UP) || (cmd_i == PADDLE_DOWN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q   <= '0;
            paddle_q <= PADDLE_IDLE;
        end else if (!en_i) begin
            hold_q   <= '0;
            paddle_q <= PADDLE_IDLE;
        end else if (cmd_valid_i) begin
            if (is_move) begin
                hold_q   <= HOLD_LOAD;
                paddle_q <= cmd_i;
            end else begin
                hold_q   <= '0;
                paddle_q <= PADDLE_IDLE;
            end
        end else if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
        end else begin
            paddle_q <= PADDLE_IDLE;
        end
    end

    assign paddle_control_o = paddle_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer for the Pong Game datapath: runs NUM_ROUNDS rounds, drives
// the Game start/end handshakes, gates paddle commands and keeps session totals.
module game_session_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS    = 8,
    parameter int unsigned REST_CYCLES   = 16,
    parameter int unsigned ROUND_TIMEOUT = 4096,
    parameter int unsigned CMD_HOLD      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             session_start,
    input  logic             session_abort,
    output logic             game_start_valid,
    input  logic             game_start_ready,
    output logic             game_end_valid,
    input  logic             game_end_ready,
    input  logic             result_en,
    input  logic             game_result,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic [1:0]       paddle_control,
    output logic             busy,
    output logic             done,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] win_total,
    output logic [CNT_W-1:0] lose_total
);

    localparam int TMR_W = (ROUND_TIMEOUT > 2) ? $clog2(ROUND_TIMEOUT) : 1;
    localparam int RST_W = $clog2(REST_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(ROUND_TIMEOUT - 1);
    localparam logic [RST_W-1:0] REST_LOAD   = RST_W'(REST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROUNDS_LAST = CNT_W'(NUM_ROUNDS);

    state_e            state_q;
    logic [CNT_W-1:0]  round_q;
    logic [CNT_W-1:0]  win_q;
    logic [CNT_W-1:0]  lose_q;
    logic [TMR_W-1:0]  timer_q;
    logic [RST_W-1:0]  rest_q;
    logic              timeout_q;
    logic              abort_q;
    logic              result_en_q;
    logic              start_valid_q;
    logic              end_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              result_rise;
    logic              timer_hit;
    logic              paddle_en;
    logic [CNT_W-1:0]  round_next;

    assign result_rise = result_en && !result_en_q;
    assign timer_hit   = (timer_q == TMR_LAST);
    assign round_next  = round_q + 1'b1;
    // Drop the gate on the cycle RUN is left so the hold is gone in the next state.
    assign paddle_en   = (state_q == ST_RUN) && !result_rise && !timer_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            round_q       <= '0;
            win_q         <= '0;
            lose_q        <= '0;
            timer_q       <= '0;
            rest_q        <= '0;
            timeout_q     <= 1'b0;
            abort_q       <= 1'b0;
            result_en_q   <= 1'b0;
            start_valid_q <= 1'b0;
            end_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            result_en_q <= result_en;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (session_start) begin
                        round_q       <= '0;
                        win_q         <= '0;
                        lose_q        <= '0;
                        timeout_q     <= 1'b0;
                        abort_q       <= 1'b0;
                        start_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ST_START;
                    end
                end
                ST_START: begin
                    if (session_abort) begin
                        start_valid_q <= 1'b0;
                        if (game_end_ready) begin
                            end_valid_q <= 1'b1;
                            state_q     <= ST_FINISH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else if (start_valid_q && game_start_ready) begin
                        start_valid_q <= 1'b0;
                        timer_q       <= '0;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    timer_q <= timer_q + 1'b1;
                    if (session_abort) begin
                        abort_q <= 1'b1;
                    end
                    if (result_rise) begin
                        round_q <= round_next;
                        if (game_result) begin
                            win_q <= sat_inc(win_q);
                        end else begin
                            lose_q <= sat_inc(lose_q);
                        end
                        if ((round_next == ROUNDS_LAST) || abort_q || session_abort) begin
                            end_valid_q <= 1'b1;
                            state_q     <= ST_FINISH;
                        end else begin
                            rest_q  <= REST_LOAD;
                            state_q <= ST_REST;
                        end
                    end else if (timer_hit) begin
                        // Game is mid-round and cannot take an end handshake; it must be reset externally.
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_REST: begin
                    if (session_abort) begin
                        end_valid_q <= 1'b1;
                        state_q     <= ST_FINISH;
                    end else if (rest_q == '0) begin
                        start_valid_q <= 1'b1;
                        state_q       <= ST_START;
                    end else begin
                        rest_q <= rest_q - 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (end_valid_q && game_end_ready) begin
                        end_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    start_valid_q <= 1'b0;
                    end_valid_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    paddle_cmd_hold #(
        .CMD_HOLD (CMD_HOLD)
    ) u_paddle_hold (
        .clk_i            (clk),
        .rst_ni           (reset),
        .cmd_i            (cmd),
        .cmd_valid_i      (cmd_valid),
        .en_i             (paddle_en),
        .paddle_control_o (paddle_control)
    );

    assign game_start_valid = start_valid_q;
    assign game_end_valid   = end_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign timeout_flag     = timeout_q;
    assign round_count      = round_q;
    assign win_total        = win_q;
    assign lose_total       = lose_q;

endmodule
